// File: rtl/mips32_fetch_queue_if.sv
// Fetch-queue bus bundle: the instruction-memory read port, the redirect
// input and the ID-stage valid/ready handshake. The master side is the fetch
// queue and the slave side is the memory/decode environment.
interface mips32_fetch_queue_if #(
    parameter int AW = 10
);
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_ir;
    logic [31:0]   id_npc;
    logic          halted;
    logic [31:0]   pc;

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output id_valid,
        input  id_ready,
        output id_ir, id_npc, halted, pc
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_ir, id_npc, halted, pc
    );
endinterface

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction fetch front-end. Owns the PC, issues one word read per
// cycle while the FIFO has credit for it, buffers {IR, NPC} pairs for the ID
// stage, flushes on redirect and stops fetching once an HLT is captured.
module mips32_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 10,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [5:0]  HLT_OP   = 6'b111111
) (
    input  logic                  clk1,
    input  logic                  rst,
    mips32_fetch_queue_if.master  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            inflight;
    logic            stop;
    logic [31:0]     pc_q;
    logic [31:0]     inflight_pc;

    logic            hlt_arriving;
    logic [CW:0]     occupancy;
    logic            issue;
    logic            enq;
    logic            deq;
    logic            id_valid_w;
    entry_t          head;

    // A response is HLT when the word returned for the in-flight read carries
    // the HLT opcode; it must block the issue that would otherwise go out in
    // the same cycle.
    assign hlt_arriving = inflight && (bus.imem_rdata[31:26] == HLT_OP);

    // Credit counts buffered entries plus the read already in flight, using
    // occupancy before this cycle's dequeue.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue     = !rst && !stop && !bus.redirect_valid && !hlt_arriving
                       && (occupancy < (CW+1)'(DEPTH));

    // A redirect squashes both the arriving response and any handshake.
    assign enq        = inflight && !bus.redirect_valid;
    assign id_valid_w = (count != '0);
    assign deq        = id_valid_w && bus.id_ready && !bus.redirect_valid;

    assign head          = fifo_q[rd_ptr];
    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q[AW-1:0];
    assign bus.id_valid  = id_valid_w;
    assign bus.id_ir     = head.ir;
    assign bus.id_npc    = head.npc;
    assign bus.halted    = stop;
    assign bus.pc        = pc_q;

    // Control state: PC, in-flight tracking, pointers, occupancy and HLT stop.
    always_ff @(posedge clk1) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            pc_q        <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            stop        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (bus.redirect_valid) begin
            pc_q     <= bus.redirect_pc;
            inflight <= 1'b0;
            stop     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                inflight_pc <= pc_q;
                pc_q        <= pc_q + 32'd1;
                inflight    <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end

            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (hlt_arriving) begin
                    stop <= 1'b1;
                end
            end

            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: each response is written with its fetch address + 1.
    always_ff @(posedge clk1) begin
        // NOTE: the storage array is cleared on reset because the head slot
        // drives id_ir/id_npc directly and must read as zero after reset.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (enq) begin
            fifo_q[wr_ptr] <= '{ir: bus.imem_rdata, npc: inflight_pc + 32'd1};
        end
    end
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_mips32_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          AW       = 10;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [5:0]  HLT_OP   = 6'b111111;
    localparam logic [31:0] HLT_WORD = 32'hFC00_0000;

    logic clk1;
    logic rst;

    mips32_fetch_queue_if #(.AW(AW)) bus ();

    mips32_fetch_queue #(
        .DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC), .HLT_OP(HLT_OP)
    ) dut (
        .clk1(clk1),
        .rst (rst),
        .bus (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Instruction memory: registered read, data valid one cycle after imem_en.
    logic [31:0] mem [1024];
    always @(posedge clk1) begin
        if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
    end

    int checks_n = 0;
    int errors_n = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_n++;
        if (act !== exp) begin
            errors_n++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered instructions, one pending read.
    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
    } ent_t;

    ent_t        q[$];
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_pc;
    logic        m_stop;
    logic        m_fresh;
    logic        m_known;

    // Observations used by directed scenarios.
    int          reads_n;
    logic        read4;
    logic [31:0] delivered[$];

    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] word;
        logic        hlt_arr;
        logic        exp_en;
        logic        enq;
        logic        deq;
        ent_t        e;
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.id_ready       = rdy;
        @(negedge clk1);
        word    = mem[m_pend_pc[AW-1:0]];
        hlt_arr = m_pend && (word[31:26] == HLT_OP);
        exp_en  = !r && !m_stop && !rv && !hlt_arr && ((q.size() + int'(m_pend)) < DEPTH);
        if (m_known) begin
            check("imem_en", 32'(bus.imem_en), 32'(exp_en));
            check("imem_addr", 32'(bus.imem_addr), 32'(m_pc[AW-1:0]));
            check("id_valid", 32'(bus.id_valid), 32'(q.size() != 0));
            check("halted", 32'(bus.halted), 32'(m_stop));
            check("pc", bus.pc, m_pc);
            if (q.size() != 0) begin
                check("id_ir", bus.id_ir, q[0].ir);
                check("id_npc", bus.id_npc, q[0].npc);
            end else if (m_fresh) begin
                check("id_ir_rst", bus.id_ir, 32'h0);
                check("id_npc_rst", bus.id_npc, 32'h0);
            end
        end
        if (bus.imem_en) begin
            reads_n++;
            if (bus.imem_addr == AW'(4)) read4 = 1'b1;
        end
        if (bus.id_valid && rdy && !rv && !r) delivered.push_back(bus.id_ir);

        if (r) begin
            q.delete();
            m_pend  = 1'b0;
            m_stop  = 1'b0;
            m_pc    = RESET_PC;
            m_fresh = 1'b1;
            m_known = 1'b1;
        end else if (rv) begin
            q.delete();
            m_pend = 1'b0;
            m_stop = 1'b0;
            m_pc   = rpc;
        end else begin
            enq = m_pend;
            deq = (q.size() != 0) && rdy;
            if (deq) void'(q.pop_front());
            if (enq) begin
                e.ir  = word;
                e.npc = m_pend_pc + 32'd1;
                q.push_back(e);
                m_fresh = 1'b0;
                if (hlt_arr) m_stop = 1'b1;
            end
            if (q.size() > DEPTH) begin
                errors_n++;
                $display("FAIL model_overflow: got %0d expected <= %0d", q.size(), DEPTH);
            end
            if (exp_en) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd1;
                m_pend    = 1'b1;
            end else begin
                m_pend = 1'b0;
            end
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic base_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        reads_n = 0;
        read4   = 1'b0;
        delivered.delete();
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        m_known = 1'b0;
        m_pend = 1'b0; m_pend_pc = '0; m_pc = '0; m_stop = 1'b0; m_fresh = 1'b0;
        reads_n = 0; read4 = 1'b0;
        rst = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
        base_mem();
        @(posedge clk1);
        #1;

        // Straight-line fetch with the decoder always ready.
        do_reset(2);
        run(12, 1'b1);
        check("p1_count", 32'(delivered.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < delivered.size(); i++)
            check("p1_order", delivered[i], 32'h1000_0000 + 32'(i));

        // Decoder stalled: exactly DEPTH reads, then drain across the wrap.
        do_reset(1);
        run(10, 1'b0);
        check("p2_reads", 32'(reads_n), 32'(DEPTH));
        check("p2_full_en", 32'(bus.imem_en), 32'd0);
        run(12, 1'b1);
        check("p2_count", 32'(delivered.size() >= 8), 32'd1);
        for (int i = 0; i < delivered.size(); i++)
            check("p2_order", delivered[i], 32'h1000_0000 + 32'(i));

        // HLT at word 3.
        mem[3] = HLT_WORD;
        do_reset(1);
        run(12, 1'b1);
        check("p3_halted", 32'(bus.halted), 32'd1);
        check("p3_pc", bus.pc, 32'd4);
        check("p3_read4", 32'(read4), 32'd0);
        check("p3_delivered", 32'(delivered.size()), 32'd4);

        // Redirect with three entries buffered and one read in flight.
        mem[3] = 32'h1000_0003;
        do_reset(1);
        run(4, 1'b0);
        step(1'b0, 1'b1, 32'h20, 1'b0);
        check("p4_flush", 32'(bus.id_valid), 32'd0);
        run(2, 1'b0);
        check("p4_valid", 32'(bus.id_valid), 32'd1);
        check("p4_ir", bus.id_ir, 32'h1000_0020);
        check("p4_npc", bus.id_npc, 32'h21);
        run(6, 1'b1);

        // Redirect in the same cycle the HLT response arrives.
        mem[3] = HLT_WORD;
        do_reset(1);
        run(4, 1'b1);
        step(1'b0, 1'b1, 32'h40, 1'b1);
        run(6, 1'b1);
        check("p5_halted", 32'(bus.halted), 32'd0);
        check("p5_count", 32'(delivered.size() >= 4), 32'd1);
        if (delivered.size() >= 4) check("p5_resume", delivered[2], 32'h1000_0040);

        // Single-cycle reset with a full FIFO.
        mem[3] = 32'h1000_0003;
        do_reset(1);
        run(8, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("p6_valid", 32'(bus.id_valid), 32'd0);
        check("p6_ir", bus.id_ir, 32'h0);
        check("p6_pc", bus.pc, RESET_PC);
        check("p6_halted", 32'(bus.halted), 32'd0);
        delivered.delete();
        run(8, 1'b1);
        if (delivered.size() > 0) check("p6_restart", delivered[0], 32'h1000_0000);
        else check("p6_restart_cnt", 32'(delivered.size()), 32'd1);

        // Randomized traffic with sparse HLT words, redirects and resets.
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? (HLT_WORD | 32'(i)) : $urandom() & 32'h03FF_FFFF;
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            logic        r;
            logic        rv;
            logic [31:0] rpc;
            r  = ($urandom_range(0, 199) == 0);
            rv = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFFE;
                default: rpc = 32'($urandom_range(0, 1023));
            endcase
            step(r, rv, rpc, 1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end
endmodule
